// File: rtl/uart_wb_bridge_pkg.sv
// Shared FSM encoding, command bytes and response codes for the UART-to-Wishbone bridge.
package uart_wb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WB    = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_READ  = 8'h02;
    localparam logic [7:0] RSP_ACK   = 8'h06;
    localparam logic [7:0] RSP_NAK   = 8'h15;

endpackage

// File: rtl/uart_wb_bridge_resp.sv
// Response serializer: loads 1 or 5 bytes, presents them LSB first one cycle after load.
// Holds o_tx_data/o_tx_valid until i_tx_ready; done pulses on the final transfer.
module uart_wb_bridge_resp (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        load,
    input  logic [39:0] load_bytes,
    input  logic [2:0]  load_count,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        done
);

    logic [31:0] pending;
    logic [2:0]  remaining;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            pending    <= 32'h0;
            remaining  <= 3'd0;
        end else if (load) begin
            o_tx_data  <= load_bytes[7:0];
            pending    <= load_bytes[39:8];
            remaining  <= load_count - 3'd1;
            o_tx_valid <= 1'b1;
        end else if (o_tx_valid && i_tx_ready) begin
            if (remaining == 3'd0) begin
                o_tx_valid <= 1'b0;
            end else begin
                o_tx_data <= pending[7:0];
                pending   <= {8'h00, pending[31:8]};
                remaining <= remaining - 3'd1;
            end
        end
    end

    assign done = o_tx_valid && i_tx_ready && (remaining == 3'd0);

endmodule

// File: rtl/uart_wb_bridge.sv
// UART byte-command to classic Wishbone master bridge; cyc/stb rise the cycle after the last command byte.
// RX has no backpressure (bytes in WB/RESP are dropped); optional WB timeout via UART_WB_BRIDGE_TIMEOUT_EN.
module uart_wb_bridge
    import uart_wb_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_busy
);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic        timeout;
    logic        resp_load;
    logic [39:0] resp_bytes;
    logic [2:0]  resp_count;
    logic        resp_done;

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            to_cnt <= '0;
        else if (state == WB)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end

    assign timeout = (state == WB) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Response is decided combinationally so the serializer raises o_tx_valid on the next cycle.
    always_comb begin
        resp_load  = 1'b0;
        resp_bytes = {32'h0, RSP_NAK};
        resp_count = 3'd1;
        case (state)
            IDLE: begin
                if (i_rx_valid && (i_rx_data != CMD_WRITE) && (i_rx_data != CMD_READ))
                    resp_load = 1'b1;
            end
            WB: begin
                if (i_wb_err || timeout) begin
                    resp_load = 1'b1;
                end else if (i_wb_ack) begin
                    resp_load  = 1'b1;
                    resp_bytes = {i_wb_data, RSP_ACK};
                    resp_count = o_wb_we ? 3'd1 : 3'd5;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            byte_cnt  <= 2'd0;
            o_wb_cyc  <= 1'b0;
            o_wb_stb  <= 1'b0;
            o_wb_we   <= 1'b0;
            o_wb_addr <= 32'h0;
            o_wb_data <= 32'h0;
            o_wb_sel  <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    byte_cnt <= 2'd0;
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_WRITE) begin
                            o_wb_we <= 1'b1;
                            state   <= ADDR;
                        end else if (i_rx_data == CMD_READ) begin
                            o_wb_we <= 1'b0;
                            state   <= ADDR;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (i_rx_valid) begin
                        o_wb_addr[{byte_cnt, 3'b000} +: 8] <= i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (o_wb_we) begin
                                state <= WDATA;
                            end else begin
                                state    <= WB;
                                o_wb_cyc <= 1'b1;
                                o_wb_stb <= 1'b1;
                                o_wb_sel <= 4'hF;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (i_rx_valid) begin
                        o_wb_data[{byte_cnt, 3'b000} +: 8] <= i_rx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state    <= WB;
                            o_wb_cyc <= 1'b1;
                            o_wb_stb <= 1'b1;
                            o_wb_sel <= 4'hF;
                        end
                    end
                end
                WB: begin
                    if (i_wb_ack || i_wb_err || timeout) begin
                        state    <= RESP;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        o_wb_sel <= 4'h0;
                    end
                end
                RESP: begin
                    if (resp_done)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy = (state != IDLE);

    uart_wb_bridge_resp u_resp (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .load       (resp_load),
        .load_bytes (resp_bytes),
        .load_count (resp_count),
        .i_tx_ready (i_tx_ready),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .done       (resp_done)
    );

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Scoreboard bench for uart_wb_bridge: expected TX bytes and WB transactions are queued by stimulus, popped by monitors.
module tb_uart_wb_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        cyc, stb, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sel;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        busy;

    always #5 clk = ~clk;

    uart_wb_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_tx_data  (tx_data),
        .o_tx_valid (tx_valid),
        .i_tx_ready (tx_ready),
        .o_wb_cyc   (cyc),
        .o_wb_stb   (stb),
        .o_wb_we    (we),
        .o_wb_addr  (addr),
        .o_wb_data  (wdata),
        .o_wb_sel   (sel),
        .i_wb_ack   (ack),
        .i_wb_err   (err),
        .i_wb_data  (rdata),
        .o_busy     (busy)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk_data;
    } wb_exp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  tx_q[$];
    wb_exp_t     wb_q[$];
    int          slave_mode = 0;   // 0 ack, 1 err, 2 ack+err, 3 silent
    int          slave_delay = 1;
    logic [31:0] slave_rdata = 32'h0;
    int          slave_cnt = 0;
    int          cyc_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic push_wb(input logic w, input logic [31:0] a, input logic [31:0] d, input logic c);
        wb_exp_t e;
        e.we = w; e.addr = a; e.data = d; e.chk_data = c;
        wb_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((tx_q.size() != 0 || wb_q.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s timeout tx_left=%0d wb_left=%0d busy=%0b required=empty/idle",
                     name, tx_q.size(), wb_q.size(), busy);
        end
        repeat (2) tick();
    endtask

    // Wishbone slave model
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            ack = 1'b0; err = 1'b0; slave_cnt = 0;
        end else if (ack || err) begin
            ack = 1'b0; err = 1'b0; rdata = 32'h0;
        end else if (cyc && stb) begin
            slave_cnt++;
            if (slave_cnt >= slave_delay && slave_mode != 3) begin
                ack = (slave_mode == 0) || (slave_mode == 2);
                err = (slave_mode == 1) || (slave_mode == 2);
                rdata = slave_rdata;
                slave_cnt = 0;
            end
        end else begin
            slave_cnt = 0;
        end
    end

    // Monitors
    logic       stalled = 1'b0;
    logic [7:0] stall_dat = 8'h00;
    logic       busy_chk = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled  = 1'b0;
            busy_chk = 1'b0;
        end else begin
            if (busy_chk) begin
                chk("busy_after_last", {63'h0, busy}, 64'h0);
                busy_chk = 1'b0;
            end
            if (stalled && tx_valid)
                chk("tx_stable", {56'h0, tx_data}, {56'h0, stall_dat});
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected actual=%0h required=no byte", tx_data);
                end else begin
                    logic [7:0] e;
                    e = tx_q.pop_front();
                    chk("tx_byte", {56'h0, tx_data}, {56'h0, e});
                    if (tx_q.size() == 0) busy_chk = 1'b1;
                end
                stalled = 1'b0;
            end else begin
                stalled   = tx_valid;
                stall_dat = tx_data;
            end
            if (cyc) cyc_cycles++;
            if (cyc && stb && (ack || err)) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected actual=addr %0h required=no transaction", addr);
                end else begin
                    wb_exp_t e;
                    e = wb_q.pop_front();
                    chk("wb_we",   {63'h0, we},   {63'h0, e.we});
                    chk("wb_addr", {32'h0, addr}, {32'h0, e.addr});
                    chk("wb_sel",  {60'h0, sel},  64'hF);
                    if (e.chk_data) chk("wb_data", {32'h0, wdata}, {32'h0, e.data});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_ctrl", {59'h0, cyc, stb, we, tx_valid, busy}, 64'h0);
        chk("rst_addr_data", {addr, wdata}, 64'h0);
        chk("rst_sel_txdata", {52'h0, sel, tx_data}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Write, slave acks after 2 cycles
        slave_mode = 0; slave_delay = 2;
        push_wb(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        tx_q.push_back(8'h06);
        send(8'h01); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        wait_idle("write", 200);

        // Read returning 0x12345678
        slave_mode = 0; slave_delay = 1; slave_rdata = 32'h1234_5678;
        push_wb(1'b0, 32'h0000_0004, 32'h0, 1'b0);
        tx_q.push_back(8'h06); tx_q.push_back(8'h78); tx_q.push_back(8'h56);
        tx_q.push_back(8'h34); tx_q.push_back(8'h12);
        send(8'h02); send(8'h04); send(8'h00); send(8'h00); send(8'h00);
        wait_idle("read", 200);

        // Bad byte with transmitter stalled for 5 cycles
        cyc_cycles = 0;
        tx_ready = 1'b0;
        tx_q.push_back(8'h15);
        send(8'h7A);
        repeat (5) tick();
        chk("stall_valid", {63'h0, tx_valid}, 64'h1);
        tx_ready = 1'b1;
        wait_idle("bad_byte", 50);
        chk("bad_no_wb", cyc_cycles, 0);

        // Slave error on write
        slave_mode = 1; slave_delay = 3;
        push_wb(1'b1, 32'h0000_0020, 32'h1122_3344, 1'b1);
        tx_q.push_back(8'h15);
        send(8'h01); send(8'h20); send(8'h00); send(8'h00); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        wait_idle("err_write", 200);

        // Ack and err together on read are an error
        slave_mode = 2; slave_delay = 1; slave_rdata = 32'hA5A5_A5A5;
        push_wb(1'b0, 32'h0000_0030, 32'h0, 1'b0);
        tx_q.push_back(8'h15);
        send(8'h02); send(8'h30); send(8'h00); send(8'h00); send(8'h00);
        wait_idle("ack_err", 200);

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
        // Silent slave times out after 16 cycles
        slave_mode = 3;
        tx_q.push_back(8'h15);
        send(8'h02); send(8'h40); send(8'h00); send(8'h00); send(8'h00);
        cyc_cycles = 0;
        wait_idle("timeout", 200);
        chk("timeout_cyc_len", cyc_cycles, 16);
`endif

        // Reset during WB
        slave_mode = 3;
        send(8'h02); send(8'h50); send(8'h00); send(8'h00); send(8'h00);
        repeat (3) tick();
        chk("in_wb_cyc", {63'h0, cyc}, 64'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_wb_cyc_stb_busy", {61'h0, cyc, stb, busy}, 64'h0);
        tx_q.delete(); wb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during ADDR byte 2
        send(8'h02); send(8'h04);
        rx_data = 8'h00; rx_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_addr_cyc_busy", {62'h0, cyc, busy}, 64'h0);
        rx_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fresh read with extra bytes during WB ignored
        slave_mode = 0; slave_delay = 8; slave_rdata = 32'hCAFE_F00D;
        push_wb(1'b0, 32'h0000_0008, 32'h0, 1'b0);
        tx_q.push_back(8'h06); tx_q.push_back(8'h0D); tx_q.push_back(8'hF0);
        tx_q.push_back(8'hFE); tx_q.push_back(8'hCA);
        send(8'h02); send(8'h08); send(8'h00); send(8'h00); send(8'h00);
        send(8'h01); send(8'h02); send(8'h7A);
        wait_idle("read_after_reset", 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_wb_bridge.md
UART_WB_BRIDGE -- requirements
Module: uart_wb_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of cycles a Wishbone transaction may wait for i_wb_ack or i_wb_err.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 i_clk  input  1  sole clock; all state on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_rx_data  input  8  received byte from the UART receiver.
REQ-006 i_rx_valid  input  1  single-cycle strobe qualifying i_rx_data; no backpressure.
REQ-007 o_tx_data  output  8  response byte to the UART transmitter.
REQ-008 o_tx_valid  output  1  response byte valid; held until accepted.
REQ-009 i_tx_ready  input  1  transmitter accepts o_tx_data when high with o_tx_valid.
REQ-010 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  classic Wishbone master controls.
REQ-011 o_wb_addr  output  32, o_wb_data  output  32, o_wb_sel  output  4  master address, write data, byte selects (always 4'hF during a transaction).
REQ-012 i_wb_ack, i_wb_err  input  1 each; i_wb_data  input  32  slave response.
REQ-013 o_busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement states IDLE, ADDR, WDATA, WB, RESP.
REQ-015 IDLE: byte 0x01 -> ADDR (write); byte 0x02 -> ADDR (read); any other byte -> RESP with single byte 0x15.
REQ-016 ADDR SHALL collect 4 bytes little-endian into o_wb_addr via a 2-bit byte counter; after the 4th byte go to WDATA (write) or WB (read).
REQ-017 WDATA SHALL collect 4 bytes little-endian into o_wb_data, then go to WB.
REQ-018 o_wb_cyc/o_wb_stb SHALL rise the cycle after the last command byte is accepted, stay high until a cycle sampling i_wb_ack or i_wb_err, and fall the following cycle.
REQ-019 On i_wb_ack, SHALL send 0x06; for reads, SHALL then send the captured i_wb_data as 4 bytes, LSB first.
REQ-020 On i_wb_err, SHALL send only 0x15; i_wb_ack and i_wb_err together SHALL be treated as err.
REQ-021 o_tx_valid SHALL assert the cycle after the response is determined; a byte transfers on a cycle with o_tx_valid && i_tx_ready; o_tx_data SHALL be stable while o_tx_valid is high and not yet accepted.
REQ-022 After the last response byte transfers, SHALL return to IDLE the next cycle.
REQ-023 i_rx_valid bytes arriving in WB or RESP SHALL be discarded without side effects.

Reset
REQ-024 While i_rst_n is low, SHALL force state IDLE and drive o_wb_cyc, o_wb_stb, o_wb_we, o_tx_valid and o_busy to 0; o_wb_addr, o_wb_data, o_wb_sel and o_tx_data SHALL be 0.
REQ-025 Reset assertion mid-transaction SHALL drop o_wb_cyc/o_wb_stb immediately and abandon any partial command or response.

Configuration
REQ-026 With macro UART_WB_BRIDGE_TIMEOUT_EN defined, a counter SHALL count cycles in WB; on reaching TIMEOUT_CYCLES with no ack/err, cyc/stb SHALL drop the next cycle and the response SHALL be the single byte 0x15.
REQ-027 Without UART_WB_BRIDGE_TIMEOUT_EN, no counter SHALL exist, TIMEOUT_CYCLES SHALL be unused, and WB SHALL wait indefinitely.

Structure
REQ-028 Package uart_wb_bridge_pkg SHALL hold the state enum, the command constants 0x01 and 0x02, and the response codes ACK 0x06 and NAK 0x15.
REQ-029 The response serializer (byte count, valid/ready holding) SHALL be a sub-module named uart_wb_bridge_resp; everything else SHALL be inline.

Verification
REQ-030 Write 01 | 10 00 00 00 | EF BE AD DE, slave acks after 2 cycles -> one transaction with we=1, addr=0x00000010, data=0xDEADBEEF, sel=F; TX 06.
REQ-031 Read 02 | 04 00 00 00, slave returns 0x12345678 with ack -> TX 06 78 56 34 12; o_busy falls after the last byte.
REQ-032 Bad byte 0x7A in IDLE -> TX 15, no Wishbone cycle; i_tx_ready held low for 5 cycles -> o_tx_valid/o_tx_data stay stable, then one transfer.
REQ-033 Slave asserts i_wb_err -> TX 15 only; with UART_WB_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=16 and a silent slave -> cyc drops after 16 cycles, TX 15.
REQ-034 i_rst_n pulsed low during WB and again during ADDR byte 2 -> cyc/stb low immediately; after release, a fresh full read completes correctly; extra rx bytes sent during WB are ignored.
